// File: rtl/ft245_arb_pkg.sv
// Shared constants for the FT245 host-bound arbiter and its round-robin picker.
// Frame: SYNC_BYTE, channel id, length, payload[, XOR checksum].
package ft245_arb_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_CH    = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_CHID = 3'd2;
  localparam logic [2:0] ST_LEN  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SYNC = ST_SYNC,
    S_CHID = ST_CHID,
    S_LEN  = ST_LEN,
    S_DATA = ST_DATA,
    S_CSUM = ST_CSUM,
    S_DONE = ST_DONE
  } arb_state_t;
endpackage

// File: rtl/ft245_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after i_rr_ptr, wrapping
// modulo NUM_CH. Shared with the host-to-device command dispatcher.
module rr_arbiter
  import ft245_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_rr_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);
  logic            w_found;
  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_i;

  // One spare bit so rr_ptr+k never overflows before the modulo fold.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_i     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
      w_i = w_sum[CH_W-1:0];
      if (!w_found && i_req[w_i]) begin
        w_found    = 1'b1;
        o_grant[w_i] = 1'b1;
        o_idx      = w_i;
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/ft245_tx_arbiter.sv
// Round-robin packet framer sharing the FT245 write port among NUM_CH requesters.
// Define FT245_ARB_CHECKSUM_EN to append an XOR checksum byte to each frame.
module ft245_tx_arbiter
  import ft245_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk_50mhz,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_req,
  input  logic [8*NUM_CH-1:0] ch_len,
  input  logic [8*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_pop,
  output logic [NUM_CH-1:0]   ch_grant,
  output logic                wr_en,
  output logic [7:0]          wr_data,
  input  logic                wr_full,
  output logic                busy
);
  arb_state_t        r_state;
  logic [CH_W-1:0]   r_g;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [NUM_CH-1:0] r_grant;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;

  logic [NUM_CH-1:0] w_arb_gnt;
  logic [CH_W-1:0]   w_arb_idx;
  logic              w_arb_any;
  logic              w_emit;
  logic              w_xfer;
  logic [7:0]        w_head;
  logic [7:0]        w_len_sel;

`ifdef FT245_ARB_CHECKSUM_EN
  localparam arb_state_t S_TAIL = S_CSUM;
  logic [7:0] r_csum;
`else
  localparam arb_state_t S_TAIL = S_DONE;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
    .i_req    (ch_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_gnt),
    .o_idx    (w_arb_idx),
    .o_any    (w_arb_any)
  );

  assign w_head    = ch_data[{r_g, 3'b000} +: 8];
  assign w_len_sel = ch_len[{w_arb_idx, 3'b000} +: 8];
  assign w_emit    = (r_state == S_SYNC) || (r_state == S_CHID) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
  // Reset is folded in so a byte is never strobed on the aborting edge.
  assign w_xfer    = w_emit && !wr_full && !reset;

  assign wr_en    = w_xfer;
  assign busy     = (r_state != S_IDLE);
  assign ch_grant = r_grant;
  assign ch_pop   = (r_state == S_DATA && w_xfer) ? r_grant : '0;

  always_comb begin
    wr_data = 8'h00;
    case (r_state)
      S_SYNC:  wr_data = SYNC_BYTE;
      S_CHID:  wr_data = {{(8-CH_W){1'b0}}, r_g};
      S_LEN:   wr_data = r_len;
      S_DATA:  wr_data = w_head;
`ifdef FT245_ARB_CHECKSUM_EN
      S_CSUM:  wr_data = r_csum;
`endif
      default: wr_data = 8'h00;
    endcase
  end

`ifdef FT245_ARB_CHECKSUM_EN
  always_ff @(posedge clk_50mhz) begin
    if (reset || r_state == S_IDLE)
      r_csum <= 8'h00;
    else if (w_xfer && (r_state == S_CHID || r_state == S_LEN || r_state == S_DATA))
      r_csum <= r_csum ^ wr_data;
  end
`endif

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_g      <= '0;
      r_rr_ptr <= CH_W'(NUM_CH-1);
      r_grant  <= '0;
      r_len    <= 8'h00;
      r_cnt    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (w_arb_any) begin
          r_g     <= w_arb_idx;
          r_grant <= w_arb_gnt;
          r_len   <= w_len_sel;
          r_cnt   <= w_len_sel;
          r_state <= S_SYNC;
        end
        S_SYNC: if (w_xfer) r_state <= S_CHID;
        S_CHID: if (w_xfer) r_state <= S_LEN;
        S_LEN:  if (w_xfer) r_state <= (r_len == 8'h00) ? S_TAIL : S_DATA;
        S_DATA: if (w_xfer) begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_TAIL;
        end
        S_CSUM: if (w_xfer) r_state <= S_DONE;
        S_DONE: begin
          r_grant  <= '0;
          r_rr_ptr <= r_g;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Randomized self-checking bench for ft245_tx_arbiter against a frame-level model.
module tb_ft245_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_req;
  logic [31:0] ch_len;
  logic [31:0] ch_data;
  logic [3:0]  ch_pop, ch_grant;
  logic        wr_en, wr_full, busy;
  logic [7:0]  wr_data;

  int nvec = 0;
  int nerr = 0;

  // Requester model: per-channel byte source with a pop-driven read pointer.
  logic [7:0] src [4][256];
  logic [7:0] ptr [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] mptr[4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  int         mlast;

  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  int         grant_q[$];
  logic [7:0] exp_q[$];
  int         pop_cnt[4] = '{0, 0, 0, 0};
  int         pop_bad = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_grant = 4'h0;

  always #10 clk = ~clk;

  ft245_tx_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .clk_50mhz (clk),
    .reset     (reset),
    .ch_req    (ch_req),
    .ch_len    (ch_len),
    .ch_data   (ch_data),
    .ch_pop    (ch_pop),
    .ch_grant  (ch_grant),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .busy      (busy)
  );

  for (genvar i = 0; i < 4; i++) begin : g_src
    assign ch_data[8*i +: 8] = src[i][ptr[i]];
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (ch_pop[i]) ptr[i] <= ptr[i] + 8'd1;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_busy  <= busy;
    prev_grant <= ch_grant;
    if (wr_en) begin
      cap_q.push_back(wr_data);
      cap_cyc.push_back(cyc);
    end
    if (prev_busy && !busy) fall_cyc <= cyc;
    if (ch_grant != 4'h0 && prev_grant == 4'h0)
      for (int i = 0; i < 4; i++) if (ch_grant[i]) grant_q.push_back(i);
    for (int i = 0; i < 4; i++) if (ch_pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    if (ch_pop != 4'h0 && (ch_pop != ch_grant || !wr_en)) pop_bad <= pop_bad + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    cap_q.delete(); cap_cyc.delete(); grant_q.delete(); exp_q.delete();
  endtask

  // Frame model: pick next requester after the last one served, emit its frame.
  task automatic model_pkt(input logic [3:0] req, output int c);
    int x;
    logic [7:0] l, b, cs;
    c = 0;
    for (int k = 4; k >= 1; k--) begin
      x = (mlast + k) % 4;
      if (req[x]) c = x;
    end
    l = ch_len[8*c +: 8];
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(c));
    exp_q.push_back(l);
    cs = 8'(c) ^ l;
    for (int j = 0; j < int'(l); j++) begin
      b = src[c][mptr[c]];
      mptr[c] = mptr[c] + 8'd1;
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef FT245_ARB_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    mlast = c;
  endtask

  task automatic run_packet(input logic [3:0] req, output logic [3:0] g, output bit ok);
    ch_req = req;
    step();
    g = ch_grant;
    ch_req = 4'h0;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_req = 4'h0; wr_full = 1'b0; ch_len = 32'h0;
    step(); step();
    nvec++; if (ch_grant !== 4'h0) begin nerr++; $display("FAIL reset_grant got %h want 0", ch_grant); end
    nvec++; if (ch_pop !== 4'h0) begin nerr++; $display("FAIL reset_pop got %h want 0", ch_pop); end
    nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    nvec++; if (wr_data !== 8'h00) begin nerr++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    mlast = 3;
    step();
  endtask

  task automatic test_round_robin();
    bit to;
    int c;
    clear_logs();
    for (int i = 0; i < 4; i++) ch_len[8*i +: 8] = 8'($urandom_range(0, 3));
    ch_len[7:0] = 8'd1;
    ch_req = 4'hF;
    to = 1'b1;
    for (int t = 0; t < 400; t++) begin
      step();
      if (grant_q.size() >= 8) begin to = 1'b0; break; end
    end
    ch_req = 4'h0;
    for (int t = 0; t < 100 && busy; t++) step();
    nvec++; if (to || busy) begin nerr++; $display("FAIL rr_timeout got grants=%0d busy=%b want 8 grants idle", grant_q.size(), busy); end
    for (int k = 0; k < 8; k++) begin
      model_pkt(4'hF, c);
      nvec++;
      if (k >= grant_q.size() || grant_q[k] !== c) begin
        nerr++; $display("FAIL rr_order[%0d] got %0d want %0d", k, (k < grant_q.size()) ? grant_q[k] : -1, c);
      end
    end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL rr_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rr_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single();
    logic [3:0] g;
    bit ok;
    int c, base[4], last;
    clear_logs();
    base = pop_cnt;
    src[1][mptr[1]]         = 8'h11;
    src[1][mptr[1] + 8'd1]  = 8'h22;
    src[1][mptr[1] + 8'd2]  = 8'h33;
    ch_len[15:8] = 8'd3;
    run_packet(4'b0010, g, ok);
    model_pkt(4'b0010, c);
    @(negedge clk); #1;
    nvec++; if (g !== 4'b0010) begin nerr++; $display("FAIL single_grant got %b want 0010", g); end
    nvec++; if (!ok) begin nerr++; $display("FAIL single_timeout got busy want idle"); end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL single_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL single_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    if (cap_q.size() == exp_q.size()) begin
      last = cap_cyc[cap_cyc.size()-1];
      nvec++; if (last - cap_cyc[0] !== exp_q.size() - 1) begin nerr++; $display("FAIL single_contig got %0d want %0d", last - cap_cyc[0], exp_q.size() - 1); end
      nvec++; if (fall_cyc - last !== 2) begin nerr++; $display("FAIL single_busy_gap got %0d want 2", fall_cyc - last); end
    end
    nvec++; if (pop_cnt[1] - base[1] !== 3) begin nerr++; $display("FAIL single_pops got %0d want 3", pop_cnt[1] - base[1]); end
    nvec++; if (pop_cnt[0] + pop_cnt[2] + pop_cnt[3] - base[0] - base[2] - base[3] !== 0) begin
      nerr++; $display("FAIL single_stray_pop got nonzero want 0");
    end
  endtask

  task automatic test_backpressure();
    int c, base;
    clear_logs();
    base = pop_cnt[0];
    ch_len[7:0] = 8'd4;
    ch_req = 4'b0001;
    step();
    ch_req = 4'h0;
    for (int t = 0; t < 20 && cap_q.size() < 4; t++) step();
    model_pkt(4'b0001, c);
    wr_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL bp_wr_en[%0d] got %b want 0", s, wr_en); end
      nvec++; if (ch_pop !== 4'h0) begin nerr++; $display("FAIL bp_pop[%0d] got %h want 0", s, ch_pop); end
      nvec++; if (wr_data !== exp_q[4]) begin nerr++; $display("FAIL bp_hold[%0d] got %h want %h", s, wr_data, exp_q[4]); end
      step();
    end
    wr_full = 1'b0;
    for (int t = 0; t < 100 && busy; t++) step();
    nvec++; if (busy) begin nerr++; $display("FAIL bp_timeout got busy want idle"); end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL bp_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL bp_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    nvec++; if (pop_cnt[0] - base !== 4) begin nerr++; $display("FAIL bp_pops got %0d want 4", pop_cnt[0] - base); end
  endtask

  task automatic test_zero_len();
    logic [3:0] g;
    bit ok;
    int c, base[4], tot;
    clear_logs();
    base = pop_cnt;
    ch_len[31:24] = 8'd0;
    run_packet(4'b1000, g, ok);
    model_pkt(4'b1000, c);
    nvec++; if (g !== 4'b1000 || !ok) begin nerr++; $display("FAIL zero_grant got %b ok=%b want 1000", g, ok); end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL zero_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL zero_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    tot = 0;
    for (int i = 0; i < 4; i++) tot += pop_cnt[i] - base[i];
    nvec++; if (tot !== 0) begin nerr++; $display("FAIL zero_pops got %0d want 0", tot); end
  endtask

  task automatic test_two_byte();
    logic [3:0] g;
    bit ok;
    int c;
    clear_logs();
    src[2][mptr[2]]        = 8'h0F;
    src[2][mptr[2] + 8'd1] = 8'hF0;
    ch_len[23:16] = 8'd2;
    run_packet(4'b0100, g, ok);
    model_pkt(4'b0100, c);
    nvec++; if (g !== 4'b0100 || !ok) begin nerr++; $display("FAIL csum_grant got %b ok=%b want 0100", g, ok); end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL csum_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL csum_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
`ifdef FT245_ARB_CHECKSUM_EN
    nvec++; if (cap_q.size() != 6 || cap_q[5] !== 8'hFF) begin nerr++; $display("FAIL csum_value got size %0d want FF at byte 5", cap_q.size()); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    bit ok;
    int c;
    clear_logs();
    ch_len[7:0] = 8'd5;
    ch_req = 4'b0001;
    step();
    ch_req = 4'h0;
    for (int t = 0; t < 20 && cap_q.size() < 5; t++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL rmid_wr_en got %b want 0", wr_en); end
    nvec++; if (ch_grant !== 4'h0) begin nerr++; $display("FAIL rmid_grant got %h want 0", ch_grant); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) mptr[i] = ptr[i];
    mlast = 3;
    clear_logs();
    ch_len[7:0]   = 8'($urandom_range(0, 4));
    ch_len[23:16] = 8'($urandom_range(0, 4));
    run_packet(4'b0101, g, ok);
    model_pkt(4'b0101, c);
    nvec++; if (g !== 4'b0001 || !ok) begin nerr++; $display("FAIL rmid_regrant got %b ok=%b want 0001", g, ok); end
    nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL rmid_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rmid_byte[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] g, req, eg;
    bit ok;
    int c;
    for (int it = 0; it < 12; it++) begin
      clear_logs();
      for (int i = 0; i < 4; i++) ch_len[8*i +: 8] = 8'($urandom_range(0, 6));
      req = 4'($urandom_range(1, 15));
      run_packet(req, g, ok);
      model_pkt(req, c);
      eg = 4'b0001 << c;
      nvec++; if (g !== eg || !ok) begin nerr++; $display("FAIL rand%0d_grant got %b ok=%b want %b", it, g, ok, eg); end
      nvec++; if (cap_q.size() !== exp_q.size()) begin nerr++; $display("FAIL rand%0d_len got %0d want %0d", it, cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        nvec++; if (cap_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rand%0d_byte[%0d] got %h want %h", it, i, cap_q[i], exp_q[i]); end
      end
    end
    nvec++; if (pop_bad !== 0) begin nerr++; $display("FAIL pop_legality got %0d bad pops want 0", pop_bad); end
  endtask

  initial begin
    reset = 1'b1; ch_req = 4'h0; ch_len = 32'h0; wr_full = 1'b0; mlast = 3;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 256; j++) src[i][j] = 8'($urandom);
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_zero_len();
    test_two_byte();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
